mux_pipe_nto1: RTL and testbench

Parametrised, registered N-to-1 word multiplexer with a valid/ready handshake on both sides, for operand and write-back selection in the pipelined datapath. It extends the single-cycle 2:1 word select to any width and input count, puts a pipeline register on the output, flags out-of-range selects and counts delivered beats. An optional skid buffer gives full throughput with a registered `in_ready`.

---
 rtl/mux_pipe_nto1.sv | 186 ++++++++++++++++++
 tb/tb_mux_pipe_nto1.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_nto1.sv
// mux_pipe_nto1 -- registered N-to-1 word multiplexer with valid/ready on
// both sides, out-of-range select flagging and an output transfer counter.
//
// Build option: define MUX_PIPE_SKID_EN to get a two-entry (main + skid)
// output stage with a registered in_ready. Without it a single output
// register is used and in_ready is combinational from out_ready.
module mux_pipe_nto1 #(
    parameter int WIDTH    = 32,
    parameter int N_INPUTS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          select,
    input  logic [N_INPUTS*WIDTH-1:0] data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      sel_err,
    output logic [15:0]               xfer_cnt
);

    // ------------------------------------------------------------------
    // Candidate selection (combinational, captured on input transfer)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] words [N_INPUTS];
    logic [WIDTH-1:0] pick_data;
    logic [31:0]      sel_ext;
    logic             pick_err;

    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_words
            assign words[gi] = data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign sel_ext  = 32'(select);
    assign pick_err = (sel_ext >= 32'(N_INPUTS));

    // Out-of-range selects match no candidate and therefore yield all zeros.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (sel_ext == 32'(i)) begin
                pick_data = words[i];
            end
        end
    end

    logic in_xfer;
    logic out_xfer;

    logic             out_valid_reg;
    logic [WIDTH-1:0] main_data_reg;
    logic [SEL_W-1:0] main_sel_reg;
    logic             main_err_reg;

    assign out_valid = out_valid_reg;
    assign data_out  = main_data_reg;
    assign out_sel   = main_sel_reg;
    assign sel_err   = main_err_reg;
    assign out_xfer  = out_valid_reg && out_ready;

`ifdef MUX_PIPE_SKID_EN
    // ------------------------------------------------------------------
    // Two-entry output stage: main register feeds the output, skid register
    // catches the beat that arrives in the cycle back-pressure is first seen.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_reg;
    logic             in_ready_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic [SEL_W-1:0] skid_sel_reg;
    logic             skid_err_reg;

    assign in_ready = in_ready_reg;
    assign in_xfer  = in_valid && in_ready_reg;

    // Occupancy FSM; in_ready and out_valid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            main_data_reg <= '0;
            main_sel_reg  <= '0;
            main_err_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_sel_reg  <= '0;
            skid_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_data_reg <= pick_data;
                        main_sel_reg  <= select;
                        main_err_reg  <= pick_err;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_ready) begin
                        // Output stalled: park the new beat behind main.
                        skid_data_reg <= pick_data;
                        skid_sel_reg  <= select;
                        skid_err_reg  <= pick_err;
                        in_ready_reg  <= 1'b0;
                        state_reg     <= ST_FULL;
                    end else if (in_xfer) begin
                        main_data_reg <= pick_data;
                        main_sel_reg  <= select;
                        main_err_reg  <= pick_err;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        main_data_reg <= skid_data_reg;
                        main_sel_reg  <= skid_sel_reg;
                        main_err_reg  <= skid_err_reg;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_ONE;
                    end
                end
                default: begin
                    state_reg     <= ST_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end
`else
    // ------------------------------------------------------------------
    // Single output register: accept whenever it is empty or draining.
    // ------------------------------------------------------------------
    assign in_ready = !out_valid_reg || out_ready;
    assign in_xfer  = in_valid && in_ready;

    // Output register: load on input transfer, otherwise empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            main_data_reg <= '0;
            main_sel_reg  <= '0;
            main_err_reg  <= 1'b0;
        end else if (in_xfer) begin
            main_data_reg <= pick_data;
            main_sel_reg  <= select;
            main_err_reg  <= pick_err;
            out_valid_reg <= 1'b1;
        end else if (out_xfer) begin
            out_valid_reg <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Delivered-beat counter, wraps naturally at 16 bits
    // ------------------------------------------------------------------
    logic [15:0] xfer_cnt_reg;

    assign xfer_cnt = xfer_cnt_reg;

    // Count every output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_reg <= '0;
        end else if (out_xfer) begin
            xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Self-checking bench for mux_pipe_nto1. A queue-based reference model of
// the output stage predicts in_ready, out_valid, the head beat and the
// transfer count; works with or without MUX_PIPE_SKID_EN.
module tb_mux_pipe_nto1;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;
`ifdef MUX_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT: 4 inputs
    logic          in_valid, in_ready, out_valid, out_ready, sel_err;
    logic [SW-1:0] select, out_sel;
    logic [N*W-1:0] data_in;
    logic [W-1:0]  data_out;
    logic [15:0]   xfer_cnt;

    // second DUT: 3 inputs, exercises the out-of-range select
    logic          in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
    logic [SW-1:0] select3, out_sel3;
    logic [3*W-1:0] data_in3;
    logic [W-1:0]  data_out3;
    logic [15:0]   xfer_cnt3;

    mux_pipe_nto1 #(.WIDTH(W), .N_INPUTS(N), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .select(select), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .out_sel(out_sel),
        .sel_err(sel_err), .xfer_cnt(xfer_cnt)
    );

    mux_pipe_nto1 #(.WIDTH(W), .N_INPUTS(3), .SEL_W(SW)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .select(select3), .data_in(data_in3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .data_out(data_out3), .out_sel(out_sel3),
        .sel_err(sel_err3), .xfer_cnt(xfer_cnt3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: FIFO of held beats plus a transfer counter
    logic [W-1:0]  q_data[$];
    logic [SW-1:0] q_sel[$];
    logic          q_err[$];
    logic [15:0]   m_cnt;

    function automatic logic [W-1:0] ref_word(input logic [N*W-1:0] d, input logic [SW-1:0] s);
        if (int'(s) < N) return d[int'(s)*W +: W];
        return '0;
    endfunction

    task automatic model_clear();
        q_data.delete();
        q_sel.delete();
        q_err.delete();
        m_cnt = 16'd0;
    endtask

    // Called at a negedge; drives one cycle, checks, returns at next negedge.
    task automatic drive_cycle(input logic iv, input logic [SW-1:0] s,
                               input logic [N*W-1:0] d, input logic ordy,
                               output bit accepted);
        logic exp_rdy, exp_v;
        in_valid  = iv;
        select    = s;
        data_in   = d;
        out_ready = ordy;
        #1;
        exp_rdy = SKID ? (q_data.size() < 2) : (q_data.size() == 0 || ordy);
        exp_v   = (q_data.size() > 0);
        n_checks++;
        if (in_ready !== exp_rdy) $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
        else n_pass++;
        n_checks++;
        if (out_valid !== exp_v) $display("FAIL out_valid: got %b expected %b", out_valid, exp_v);
        else n_pass++;
        if (exp_v) begin
            n_checks++;
            if (data_out !== q_data[0] || out_sel !== q_sel[0] || sel_err !== q_err[0])
                $display("FAIL out_beat: got data=%h sel=%0d err=%b expected data=%h sel=%0d err=%b",
                         data_out, out_sel, sel_err, q_data[0], q_sel[0], q_err[0]);
            else n_pass++;
        end
        n_checks++;
        if (xfer_cnt !== m_cnt) $display("FAIL xfer_cnt: got %h expected %h", xfer_cnt, m_cnt);
        else n_pass++;
        accepted = iv && exp_rdy;
        @(posedge clk);
        if (exp_v && ordy) begin
            void'(q_data.pop_front());
            void'(q_sel.pop_front());
            void'(q_err.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (accepted) begin
            q_data.push_back(ref_word(d, s));
            q_sel.push_back(s);
            q_err.push_back(int'(s) >= N);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_valid3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (data_out !== '0) $display("FAIL reset_data_out: got %h expected 0", data_out);
        else n_pass++;
        n_checks++;
        if (out_sel !== '0 || sel_err !== 1'b0)
            $display("FAIL reset_sel: got sel=%0d err=%b expected 0 0", out_sel, sel_err);
        else n_pass++;
        n_checks++;
        if (xfer_cnt !== 16'd0) $display("FAIL reset_xfer_cnt: got %h expected 0", xfer_cnt);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_select();
        bit a;
        logic [N*W-1:0] d;
        do_reset();
        d = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        drive_cycle(1'b1, 2'd2, d, 1'b1, a);
        n_checks++;
        if (out_valid !== 1'b1 || data_out !== 32'h0000_00A2 || sel_err !== 1'b0)
            $display("FAIL select_word: got v=%b data=%h err=%b expected 1 000000a2 0",
                     out_valid, data_out, sel_err);
        else n_pass++;
        drive_cycle(1'b0, 2'd0, d, 1'b1, a);
        n_checks++;
        if (xfer_cnt !== 16'd1) $display("FAIL select_cnt: got %h expected 1", xfer_cnt);
        else n_pass++;
        $display("test_select: data_out=%h xfer_cnt=%0d", data_out, xfer_cnt);
    endtask

    task automatic test_sel_err();
        logic [3*W-1:0] d3;
        d3 = {32'h33, 32'h22, 32'h11};
        @(negedge clk);
        in_valid3 = 1'b1; select3 = 2'd3; data_in3 = d3; out_ready3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b1; select3 = 2'd1;
        n_checks++;
        if (out_valid3 !== 1'b1 || data_out3 !== '0 || sel_err3 !== 1'b1 || out_sel3 !== 2'd3)
            $display("FAIL sel_err_beat: got v=%b data=%h err=%b sel=%0d expected 1 0 1 3",
                     out_valid3, data_out3, sel_err3, out_sel3);
        else n_pass++;
        @(negedge clk);
        in_valid3 = 1'b0;
        n_checks++;
        if (out_valid3 !== 1'b1 || data_out3 !== 32'h22 || sel_err3 !== 1'b0 || out_sel3 !== 2'd1)
            $display("FAIL sel_ok_beat: got v=%b data=%h err=%b sel=%0d expected 1 22 0 1",
                     out_valid3, data_out3, sel_err3, out_sel3);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid3 !== 1'b0 || xfer_cnt3 !== 16'd2)
            $display("FAIL sel_err_cnt: got v=%b cnt=%0d expected 0 2", out_valid3, xfer_cnt3);
        else n_pass++;
        $display("test_sel_err: out_sel=3 flagged, xfer_cnt3=%0d", xfer_cnt3);
    endtask

    task automatic test_back_to_back();
        bit a;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, SW'(i % 4), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, a);
            n_checks++;
            if (!a) $display("FAIL stream_accept: got 0 expected 1 at beat %0d", i);
            else n_pass++;
        end
        drive_cycle(1'b0, 2'd0, '0, 1'b1, a);
        n_checks++;
        if (xfer_cnt !== 16'd8) $display("FAIL stream_cnt: got %0d expected 8", xfer_cnt);
        else n_pass++;
        $display("test_back_to_back: xfer_cnt=%0d", xfer_cnt);
    endtask

    task automatic test_stall();
        bit a;
        int acc;
        do_reset();
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, SW'(i % 4), {4{32'(i + 1)}}, 1'b0, a);
            if (a) acc++;
        end
        n_checks++;
        if (acc != (SKID ? 2 : 1)) $display("FAIL stall_accepted: got %0d expected %0d", acc, SKID ? 2 : 1);
        else n_pass++;
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 2'd0, '0, 1'b1, a);
        n_checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'(acc))
            $display("FAIL stall_drain: got v=%b cnt=%0d expected 0 %0d", out_valid, xfer_cnt, acc);
        else n_pass++;
        $display("test_stall: accepted=%0d delivered=%0d", acc, xfer_cnt);
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid = 1'b1; select = 2'd0; data_in = '0; out_ready = 1'b1;
        repeat (65536) @(negedge clk);
        n_checks++;
        if (xfer_cnt !== 16'hFFFF) $display("FAIL wrap_ffff: got %h expected ffff", xfer_cnt);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (xfer_cnt !== 16'h0000) $display("FAIL wrap_zero: got %h expected 0000", xfer_cnt);
        else n_pass++;
        in_valid = 1'b0;
        $display("test_wrap: xfer_cnt=%h", xfer_cnt);
    endtask

    task automatic test_async_reset();
        bit a;
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, SW'(i), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, a);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, SW'(i), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, a);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd0)
            $display("FAIL async_reset: got v=%b cnt=%0d expected 0 0", out_valid, xfer_cnt);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL async_reset_ready: got %b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 2'd0, '0, 1'b1, a);
        $display("test_async_reset: out_valid=%b in_ready=%b", out_valid, in_ready);
    endtask

    task automatic test_random();
        bit a;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, SW'($urandom()),
                        {$urandom(), $urandom(), $urandom(), $urandom()},
                        1'($urandom_range(0, 1)), a);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 2'd0, '0, 1'b1, a);
        $display("test_random: xfer_cnt=%0d", xfer_cnt);
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; select = '0; data_in = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b1; select3 = '0; data_in3 = '0;
        test_reset();
        test_select();
        test_sel_err();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
